writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage (MEM/WB latch plus writeback select). It is the producer side of the register-file write port that Decode consumes.
- Each cycle it picks the result for the retiring instruction and drives Write_Reg_Out, Write_Data and Reg_Write_Out into Decode's register file.
- It stalls the pipeline while a load waits for memory data, flags memory timeouts, and latches processor halt.

Parameters:
- MEM_TIMEOUT, 16: maximum WAIT_MEM cycles before Err asserts.
- DATA_W, 16: datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- In_Valid  in  1  MEM stage holds a real instruction.
- In_Reg_Write  in  1  instruction writes a register.
- In_Write_Reg  in  3  destination register.
- In_WB_Sel  in  2  result select: 00 ALU, 01 memory, 10 PC2 (JAL), 11 immediate.
- In_ALU_Result  in  16  ALU result.
- In_PC2  in  16  PC+2 of the instruction.
- In_Immediate  in  16  extended immediate.
- In_Halt  in  1  instruction is HALT.
- Flush  in  1  squash the instruction being captured this edge.
- Mem_Data  in  16  load data from data memory.
- Mem_Data_Valid  in  1  Mem_Data valid this cycle.
- Write_Reg_Out  out  3  RF write address to Decode.
- Write_Data  out  16  RF write data to Decode.
- Reg_Write_Out  out  1  RF write enable to Decode.
- WB_Stall  out  1  freeze all upstream stages.
- Halted  out  1  processor halted (sticky).
- Err  out  1  memory timeout (sticky).

Behaviour:
- Reset (rst=0, async):
  - Latch valid=0, state=RUN, wait counter=0.
  - Halted=0, Err=0, Reg_Write_Out=0, WB_Stall=0.
  - Write_Reg_Out=0, Write_Data=0.
- Capture:
  - On each rising edge with WB_Stall=0 and Halted=0, latch all In_* signals.
  - Latched valid = In_Valid & ~Flush.
  - With WB_Stall=1, the latch holds its contents and Flush is ignored, because the held instruction is older and committed.
- Latency: an instruction presented at edge N drives the outputs during cycle N..N+1. Decode's register file writes at edge N+1. Decode bypasses same-cycle read-after-write internally.
- Write_Data mux from the latch: 00 ALU_Result, 01 Mem_Data (live input), 10 PC2, 11 Immediate. Write_Reg_Out = latched In_Write_Reg.
- Reg_Write_Out = valid & reg_write & ~Halted & (sel!=01 | Mem_Data_Valid).
- States:
  - RUN:
    - Valid latched entry with sel=01 and Mem_Data_Valid=0: WB_Stall=1 combinationally, next state WAIT_MEM, counter=1.
    - Valid latched entry with In_Halt=1: next state HALTED; the halt instruction itself performs no write.
  - WAIT_MEM:
    - WB_Stall=1 and counter increments each cycle.
    - When Mem_Data_Valid=1: write occurs that cycle, WB_Stall=0, next state RUN, counter cleared.
    - When counter reaches MEM_TIMEOUT with no data: Err=1, next state HALTED, no write.
  - HALTED: WB_Stall=1, Halted=1, Reg_Write_Out=0. Only reset exits.
- Boundary cases:
  - Mem_Data_Valid on the first cycle in RUN: no stall, write in the same cycle.
  - Load and halt cannot coexist; if In_Halt=1, halt takes priority and no write occurs.
  - Counter saturates at MEM_TIMEOUT.
  - Reset mid-WAIT_MEM: the pending write is dropped.
  - Invalid entries (bubbles) never write and never stall, regardless of In_WB_Sel.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output Retire_Count [15:0], reset to 0.
  - Increments by 1 each cycle a valid non-halt instruction completes. Completion is any write, or a non-writing valid instruction in a non-stalled cycle.
  - Wraps 0xFFFF to 0x0000 and freezes once Halted.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- ALU write: In_Valid=1, Reg_Write=1, reg=3, sel=00, ALU=0x1234 -> next cycle Write_Reg_Out=3, Write_Data=0x1234, Reg_Write_Out=1, WB_Stall=0.
- JAL: sel=10, PC2=0x0042, reg=7 -> Write_Data=0x0042 to R7. Same with Flush=1 -> Reg_Write_Out=0.
- Load wait: sel=01, reg=2, Mem_Data_Valid low for 3 cycles then high with 0xBEEF:
  - WB_Stall=1 for exactly 3 cycles, upstream inputs ignored meanwhile.
  - Then a single write of 0xBEEF to R2, and the next instruction is captured on the following edge.
- Timeout: MEM_TIMEOUT=4, load with Mem_Data_Valid never high -> Err=1 and Halted=1 after 4 wait cycles, no write ever issued.
- Halt: ADD to R1, then HALT, then ADD to R4 -> R1 written, Halted=1 the cycle after HALT, R4 never written, WB_Stall stays 1.
- Async reset during WAIT_MEM: rst low mid-cycle -> all outputs 0 immediately. With WB_RETIRE_COUNT_EN, 5 valid instructions -> Retire_Count=5, and 0xFFFF+1 -> 0x0000.

Source files
------------

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB latch, writeback select, load-wait stall, timeout and halt.
// Optional WB_RETIRE_COUNT_EN adds a 16-bit Retire_Count output.
module writeback_stage #(
   parameter int MEM_TIMEOUT = 16,
   parameter int DATA_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              In_Valid,
   input  logic              In_Reg_Write,
   input  logic [2:0]        In_Write_Reg,
   input  logic [1:0]        In_WB_Sel,
   input  logic [DATA_W-1:0] In_ALU_Result,
   input  logic [DATA_W-1:0] In_PC2,
   input  logic [DATA_W-1:0] In_Immediate,
   input  logic              In_Halt,
   input  logic              Flush,
   input  logic [DATA_W-1:0] Mem_Data,
   input  logic              Mem_Data_Valid,
   output logic [2:0]        Write_Reg_Out,
   output logic [DATA_W-1:0] Write_Data,
   output logic              Reg_Write_Out,
   output logic              WB_Stall,
   output logic              Halted,
`ifdef WB_RETIRE_COUNT_EN
   output logic [15:0]       Retire_Count,
`endif
   output logic              Err
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_HALTED   = 2'd2
   } wb_state_t;

   wb_state_t         state;
   logic [CNT_W-1:0]  wait_cnt;

   logic              lat_valid;
   logic              lat_reg_write;
   logic [2:0]        lat_write_reg;
   logic [1:0]        lat_sel;
   logic [DATA_W-1:0] lat_alu;
   logic [DATA_W-1:0] lat_pc2;
   logic [DATA_W-1:0] lat_imm;
   logic              lat_halt;
   logic              err_q;

   logic              sel_mem;
   logic              load_wait;
   logic              complete;

   // Halt wins over a load: a halting entry never waits on memory.
   always_comb begin
      sel_mem   = (lat_sel == 2'b01);
      load_wait = lat_valid & ~lat_halt & sel_mem & ~Mem_Data_Valid;
   end

   always_comb begin
      WB_Stall = 1'b0;
      case (state)
         S_RUN:      WB_Stall = load_wait;
         S_WAIT_MEM: WB_Stall = ~Mem_Data_Valid;
         S_HALTED:   WB_Stall = 1'b1;
         default:    WB_Stall = 1'b1;
      endcase
   end

   always_comb begin
      Write_Data = lat_alu;
      case (lat_sel)
         2'b00:   Write_Data = lat_alu;
         2'b01:   Write_Data = Mem_Data;
         2'b10:   Write_Data = lat_pc2;
         2'b11:   Write_Data = lat_imm;
         default: Write_Data = lat_alu;
      endcase
   end

   always_comb begin
      Halted        = (state == S_HALTED);
      Write_Reg_Out = lat_write_reg;
      Reg_Write_Out = lat_valid & lat_reg_write & ~lat_halt & ~Halted
                    & (~sel_mem | Mem_Data_Valid);
      complete      = lat_valid & ~lat_halt & ~Halted & ~WB_Stall;
      Err           = err_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_RUN;
         wait_cnt      <= '0;
         err_q         <= 1'b0;
         lat_valid     <= 1'b0;
         lat_reg_write <= 1'b0;
         lat_write_reg <= '0;
         lat_sel       <= '0;
         lat_alu       <= '0;
         lat_pc2       <= '0;
         lat_imm       <= '0;
         lat_halt      <= 1'b0;
      end else begin
         // A stalled entry is older and committed, so Flush cannot touch it.
         if (!WB_Stall && !Halted) begin
            lat_valid     <= In_Valid & ~Flush;
            lat_reg_write <= In_Reg_Write;
            lat_write_reg <= In_Write_Reg;
            lat_sel       <= In_WB_Sel;
            lat_alu       <= In_ALU_Result;
            lat_pc2       <= In_PC2;
            lat_imm       <= In_Immediate;
            lat_halt      <= In_Halt;
         end

         case (state)
            S_RUN: begin
               if (lat_valid && lat_halt) begin
                  state <= S_HALTED;
               end else if (load_wait) begin
                  state    <= S_WAIT_MEM;
                  wait_cnt <= CNT_W'(1);
               end
            end
            S_WAIT_MEM: begin
               if (Mem_Data_Valid) begin
                  state    <= S_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt >= CNT_MAX) begin
                  state <= S_HALTED;
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_HALTED: state <= S_HALTED;
            default:  state <= S_HALTED;
         endcase
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Retire_Count <= '0;
      end else if (complete) begin
         Retire_Count <= Retire_Count + 16'd1;
      end
   end
`else
   logic unused_complete;
   assign unused_complete = complete;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage with MEM_TIMEOUT=4.
module tb_writeback_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        In_Valid, In_Reg_Write, In_Halt, Flush, Mem_Data_Valid;
   logic [2:0]  In_Write_Reg;
   logic [1:0]  In_WB_Sel;
   logic [15:0] In_ALU_Result, In_PC2, In_Immediate, Mem_Data;
   logic [2:0]  Write_Reg_Out;
   logic [15:0] Write_Data;
   logic        Reg_Write_Out, WB_Stall, Halted, Err;
`ifdef WB_RETIRE_COUNT_EN
   logic [15:0] Retire_Count;
`endif

   int checks = 0;
   int errors = 0;
   logic [18:0] sb[$];
   logic [18:0] mon_e;

   writeback_stage #(.MEM_TIMEOUT(TO), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .In_Valid(In_Valid), .In_Reg_Write(In_Reg_Write), .In_Write_Reg(In_Write_Reg),
      .In_WB_Sel(In_WB_Sel), .In_ALU_Result(In_ALU_Result), .In_PC2(In_PC2),
      .In_Immediate(In_Immediate), .In_Halt(In_Halt), .Flush(Flush),
      .Mem_Data(Mem_Data), .Mem_Data_Valid(Mem_Data_Valid),
      .Write_Reg_Out(Write_Reg_Out), .Write_Data(Write_Data), .Reg_Write_Out(Reg_Write_Out),
      .WB_Stall(WB_Stall), .Halted(Halted),
`ifdef WB_RETIRE_COUNT_EN
      .Retire_Count(Retire_Count),
`endif
      .Err(Err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #2;
   endtask

   task automatic at_neg;
      @(negedge clk);
   endtask

   task automatic issue(input logic v, input logic rw, input logic [2:0] r, input logic [1:0] s,
                        input logic [15:0] val, input logic h, input logic f);
      In_Valid      = v;
      In_Reg_Write  = rw;
      In_Write_Reg  = r;
      In_WB_Sel     = s;
      In_ALU_Result = (s == 2'b00) ? val : 16'hA5A5;
      In_PC2        = (s == 2'b10) ? val : 16'h5A5A;
      In_Immediate  = (s == 2'b11) ? val : 16'hC3C3;
      In_Halt       = h;
      Flush         = f;
   endtask

   // Bubble that would look like a writing load if it were valid.
   task automatic idle;
      issue(1'b0, 1'b1, 3'd7, 2'b01, 16'hFFFF, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [2:0] r, input logic [15:0] d);
      sb.push_back({r, d});
   endtask

   always @(negedge clk) begin
      if (Reg_Write_Out === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 32'(Reg_Write_Out), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("wr_reg", 32'(Write_Reg_Out), 32'(mon_e[18:16]));
            check("wr_data", 32'(Write_Data), 32'(mon_e[15:0]));
         end
      end
   end

   initial begin
      rst = 1'b0;
      idle();
      Mem_Data = 16'h0000;
      Mem_Data_Valid = 1'b0;
      #1;
      check("rst_we", 32'(Reg_Write_Out), 32'd0);
      check("rst_stall", 32'(WB_Stall), 32'd0);
      check("rst_halted", 32'(Halted), 32'd0);
      check("rst_err", 32'(Err), 32'd0);
      check("rst_wreg", 32'(Write_Reg_Out), 32'd0);
      check("rst_wdata", 32'(Write_Data), 32'd0);
`ifdef WB_RETIRE_COUNT_EN
      check("rst_retire", 32'(Retire_Count), 32'd0);
`endif
      repeat (2) cyc();
      rst = 1'b1;

      // ALU, JAL, flushed JAL, immediate
      issue(1'b1, 1'b1, 3'd3, 2'b00, 16'h1234, 1'b0, 1'b0); push(3'd3, 16'h1234);
      at_neg(); check("empty_stall", 32'(WB_Stall), 32'd0); cyc();
      issue(1'b1, 1'b1, 3'd7, 2'b10, 16'h0042, 1'b0, 1'b0); push(3'd7, 16'h0042);
      at_neg(); check("alu_we", 32'(Reg_Write_Out), 32'd1); check("alu_stall", 32'(WB_Stall), 32'd0); cyc();
      issue(1'b1, 1'b1, 3'd7, 2'b10, 16'h0042, 1'b0, 1'b1);
      at_neg(); check("jal_we", 32'(Reg_Write_Out), 32'd1); cyc();
      issue(1'b1, 1'b1, 3'd5, 2'b11, 16'h7E57, 1'b0, 1'b0); push(3'd5, 16'h7E57);
      at_neg(); check("flush_we", 32'(Reg_Write_Out), 32'd0); cyc();
      idle();
      at_neg(); check("imm_we", 32'(Reg_Write_Out), 32'd1); cyc();

      // Load whose data is ready on the first cycle
      issue(1'b1, 1'b1, 3'd5, 2'b01, 16'h0000, 1'b0, 1'b0); push(3'd5, 16'h600D);
      at_neg(); check("bubble_stall", 32'(WB_Stall), 32'd0); check("bubble_we", 32'(Reg_Write_Out), 32'd0); cyc();
      Mem_Data = 16'h600D; Mem_Data_Valid = 1'b1;
      issue(1'b1, 1'b1, 3'd2, 2'b01, 16'h0000, 1'b0, 1'b0); push(3'd2, 16'hBEEF);
      at_neg(); check("ld0_stall", 32'(WB_Stall), 32'd0); cyc();

      // Load waiting three cycles while upstream presents junk with Flush
      Mem_Data = 16'hDEAD; Mem_Data_Valid = 1'b0;
      issue(1'b1, 1'b1, 3'd4, 2'b00, 16'hBAD0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         at_neg(); check("ld_stall", 32'(WB_Stall), 32'd1); check("ld_we", 32'(Reg_Write_Out), 32'd0); cyc();
      end
      Mem_Data = 16'hBEEF; Mem_Data_Valid = 1'b1;
      issue(1'b1, 1'b1, 3'd6, 2'b00, 16'h6666, 1'b0, 1'b0); push(3'd6, 16'h6666);
      at_neg(); check("ld_rel_stall", 32'(WB_Stall), 32'd0); check("ld_rel_we", 32'(Reg_Write_Out), 32'd1); cyc();
      Mem_Data_Valid = 1'b0; idle();
      at_neg(); check("r6_stall", 32'(WB_Stall), 32'd0); check("r6_we", 32'(Reg_Write_Out), 32'd1); cyc();

`ifdef WB_RETIRE_COUNT_EN
      issue(1'b1, 1'b0, 3'd1, 2'b00, 16'h0000, 1'b0, 1'b0);
      at_neg(); check("retire_6", 32'(Retire_Count), 32'd6); cyc();
      repeat (65529) cyc();
      at_neg(); check("retire_ffff", 32'(Retire_Count), 32'h0000FFFF);
      idle(); cyc();
      at_neg(); check("retire_wrap", 32'(Retire_Count), 32'd0); cyc();
`endif

      // Halt: R1 written, halt (with load select) silent, R4 dropped
      issue(1'b1, 1'b1, 3'd1, 2'b00, 16'h1111, 1'b0, 1'b0); push(3'd1, 16'h1111);
      at_neg(); cyc();
      issue(1'b1, 1'b1, 3'd0, 2'b01, 16'h0000, 1'b1, 1'b0);
      at_neg(); check("r1_we", 32'(Reg_Write_Out), 32'd1); check("pre_halt", 32'(Halted), 32'd0); cyc();
      issue(1'b1, 1'b1, 3'd4, 2'b00, 16'h4444, 1'b0, 1'b0);
      at_neg(); check("halt_we", 32'(Reg_Write_Out), 32'd0); check("halt_stall", 32'(WB_Stall), 32'd0);
      check("halt_halted", 32'(Halted), 32'd0); cyc();
      for (int i = 0; i < 4; i++) begin
         at_neg(); check("halted", 32'(Halted), 32'd1); check("halted_stall", 32'(WB_Stall), 32'd1);
         check("halted_we", 32'(Reg_Write_Out), 32'd0); cyc();
      end
      check("halt_err", 32'(Err), 32'd0);
`ifdef WB_RETIRE_COUNT_EN
      check("retire_frozen", 32'(Retire_Count), 32'd1);
`endif

      // Timeout with no memory data
      rst = 1'b0; #1;
      check("rst2_halted", 32'(Halted), 32'd0);
      cyc(); rst = 1'b1;
      issue(1'b1, 1'b1, 3'd2, 2'b01, 16'h0000, 1'b0, 1'b0);
      at_neg(); cyc();
      idle();
      for (int i = 0; i <= TO; i++) begin
         at_neg(); check("to_err", 32'(Err), 32'd0); check("to_stall", 32'(WB_Stall), 32'd1); cyc();
      end
      at_neg(); check("to_err_set", 32'(Err), 32'd1); check("to_halted", 32'(Halted), 32'd1); cyc();

      // Async reset in the middle of a memory wait
      rst = 1'b0; #1; cyc(); rst = 1'b1;
      issue(1'b1, 1'b1, 3'd3, 2'b01, 16'h0000, 1'b0, 1'b0);
      at_neg(); cyc();
      idle();
      at_neg(); check("rw_stall0", 32'(WB_Stall), 32'd1); cyc();
      at_neg(); check("rw_stall1", 32'(WB_Stall), 32'd1);
      rst = 1'b0; #1;
      check("rw_we", 32'(Reg_Write_Out), 32'd0);
      check("rw_stall", 32'(WB_Stall), 32'd0);
      check("rw_halted", 32'(Halted), 32'd0);
      check("rw_err", 32'(Err), 32'd0);
      check("rw_wreg", 32'(Write_Reg_Out), 32'd0);
      check("rw_wdata", 32'(Write_Data), 32'd0);
      Mem_Data = 16'h1111; Mem_Data_Valid = 1'b1; #1;
      check("rw_drop_we", 32'(Reg_Write_Out), 32'd0);
      cyc(); rst = 1'b1; Mem_Data_Valid = 1'b0;
      at_neg(); check("rw_after_stall", 32'(WB_Stall), 32'd0); check("rw_after_we", 32'(Reg_Write_Out), 32'd0);
      cyc();

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
